// File: rtl/vga_config_sequencer_pkg.sv
// Shared constants and types for the VGA config sequencer.
package vga_config_sequencer_pkg;

  // Default bus width and boot table length. Modules carry their own
  // CONFIG_WIDTH / NUM_REGS parameters and default them to these values.
  localparam int DEFAULT_CONFIG_WIDTH = 12;
  localparam int DEFAULT_NUM_REGS     = 8;

  // Timing register map, which is also the boot table order.
  localparam int ADDR_H_LEFT  = 0;
  localparam int ADDR_V_LEFT  = 1;
  localparam int ADDR_H_RIGHT = 2;
  localparam int ADDR_V_RIGHT = 3;
  localparam int ADDR_H_SYNC  = 4;
  localparam int ADDR_V_SYNC  = 5;
  localparam int ADDR_H_MAX   = 6;
  localparam int ADDR_V_MAX   = 7;

  // Sequencer states: BOOT replays the table, IDLE arbitrates, HOLD waits
  // for the VSync falling edge, SEND presents one runtime write.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    IDLE = 2'd1,
    HOLD = 2'd2,
    SEND = 2'd3
  } seq_state_t;

endpackage

// File: rtl/vga_config_sequencer_if.sv
// VGA config port bundle.
// Handshake: the master raises c_valid with c_addr/c_data and holds all three
// stable until a cycle with c_valid && c_ready; that cycle is the transfer.
// c_ready may be high before or in the same cycle c_valid rises.
interface vga_config_sequencer_if
  import vga_config_sequencer_pkg::*;
#(
  parameter int CONFIG_WIDTH = DEFAULT_CONFIG_WIDTH
);
  logic                    c_valid;
  logic [CONFIG_WIDTH-1:0] c_addr;
  logic [CONFIG_WIDTH-1:0] c_data;
  logic                    c_ready;

  modport master (output c_valid, output c_addr, output c_data, input c_ready);
  modport slave  (input c_valid, input c_addr, input c_data, output c_ready);
endinterface

// File: rtl/vga_cfg_rr_arbiter.sv
// Two-way round-robin arbiter. Grants are combinational; rr_last remembers
// the last winner and only moves when en is high and someone is granted.
module vga_cfg_rr_arbiter (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0_valid,
  input  logic req1_valid,
  output logic grant0,
  output logic grant1
);

  // 1 after reset so requester 0 wins the first tie.
  logic rr_last;

  // Pick the requester opposite to the last winner on a tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (rr_last) grant0 = 1'b1;
      else         grant1 = 1'b1;
    end else if (req0_valid) begin
      grant0 = 1'b1;
    end else if (req1_valid) begin
      grant1 = 1'b1;
    end
  end

  // Remember the winner of each arbitration that actually takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else if (en && (grant0 || grant1)) begin
      rr_last <= grant1;
    end
  end

endmodule

// File: rtl/vga_config_sequencer.sv
// Owns the VGA config port: replays the boot timing table after reset, then
// forwards round-robin arbitrated runtime writes, optionally aligned to the
// start of a VSync pulse so timing never changes mid-frame.
module vga_config_sequencer
  import vga_config_sequencer_pkg::*;
#(
  parameter int CONFIG_WIDTH = DEFAULT_CONFIG_WIDTH,
  parameter int NUM_REGS     = DEFAULT_NUM_REGS,
  parameter bit ALIGN_VSYNC  = 1'b1,
  parameter int H_LEFT_INIT  = 48,
  parameter int V_LEFT_INIT  = 33,
  parameter int H_RIGHT_INIT = 16,
  parameter int V_RIGHT_INIT = 10,
  parameter int H_SYNC_INIT  = 96,
  parameter int V_SYNC_INIT  = 2,
  parameter int H_MAX_INIT   = 800,
  parameter int V_MAX_INIT   = 525
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0_valid,
  input  logic [CONFIG_WIDTH-1:0] req0_addr,
  input  logic [CONFIG_WIDTH-1:0] req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [CONFIG_WIDTH-1:0] req1_addr,
  input  logic [CONFIG_WIDTH-1:0] req1_data,
  output logic                    req1_ready,
  input  logic                    vsync_in,
  vga_config_sequencer_if.master  cfg,
  output logic                    boot_done,
  output logic                    busy,
  output seq_state_t              state_dbg
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

  // Boot value for a table index; entries past the named registers boot to 0.
  function automatic logic [CONFIG_WIDTH-1:0] boot_value(input logic [IDX_W-1:0] i);
    case (int'(i))
      ADDR_H_LEFT:  return CONFIG_WIDTH'(H_LEFT_INIT);
      ADDR_V_LEFT:  return CONFIG_WIDTH'(V_LEFT_INIT);
      ADDR_H_RIGHT: return CONFIG_WIDTH'(H_RIGHT_INIT);
      ADDR_V_RIGHT: return CONFIG_WIDTH'(V_RIGHT_INIT);
      ADDR_H_SYNC:  return CONFIG_WIDTH'(H_SYNC_INIT);
      ADDR_V_SYNC:  return CONFIG_WIDTH'(V_SYNC_INIT);
      ADDR_H_MAX:   return CONFIG_WIDTH'(H_MAX_INIT);
      ADDR_V_MAX:   return CONFIG_WIDTH'(V_MAX_INIT);
      default:      return '0;
    endcase
  endfunction

  seq_state_t              state, state_d;
  logic [IDX_W-1:0]        idx, idx_d;
  logic                    c_valid_r, c_valid_d;
  logic [CONFIG_WIDTH-1:0] c_addr_r, c_addr_d;
  logic [CONFIG_WIDTH-1:0] c_data_r, c_data_d;
  logic [CONFIG_WIDTH-1:0] hold_addr, hold_addr_d;
  logic [CONFIG_WIDTH-1:0] hold_data, hold_data_d;
  logic                    req0_ready_r, req0_ready_d;
  logic                    req1_ready_r, req1_ready_d;
  logic                    boot_done_r, boot_done_d;
  logic                    vsync_q;
  logic                    grant0, grant1;
  logic                    xfer;
  logic                    vsync_fall;
  logic [CONFIG_WIDTH-1:0] sel_addr, sel_data;

  vga_cfg_rr_arbiter u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (state == IDLE),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  // Transfer, VSync edge and granted request payload.
  always_comb begin
    xfer       = c_valid_r && cfg.c_ready;
    vsync_fall = vsync_q && !vsync_in;
    sel_addr   = grant0 ? req0_addr : req1_addr;
    sel_data   = grant0 ? req0_data : req1_data;
  end

  // Next-state and next-output logic for the whole sequencer.
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    c_valid_d    = c_valid_r;
    c_addr_d     = c_addr_r;
    c_data_d     = c_data_r;
    hold_addr_d  = hold_addr;
    hold_data_d  = hold_data;
    req0_ready_d = 1'b0;
    req1_ready_d = 1'b0;
    boot_done_d  = boot_done_r;
    case (state)
      BOOT: begin
        if (!c_valid_r) begin
          // First cycle after reset: present the current table entry.
          c_valid_d = 1'b1;
          c_addr_d  = CONFIG_WIDTH'(idx);
          c_data_d  = boot_value(idx);
        end else if (xfer) begin
          if (idx == IDX_LAST) begin
            c_valid_d   = 1'b0;
            boot_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            // Back-to-back: next entry follows with c_valid kept high.
            idx_d    = idx + 1'b1;
            c_addr_d = CONFIG_WIDTH'(idx + 1'b1);
            c_data_d = boot_value(idx + 1'b1);
          end
        end
      end
      IDLE: begin
        if (grant0 || grant1) begin
          hold_addr_d  = sel_addr;
          hold_data_d  = sel_data;
          req0_ready_d = grant0;
          req1_ready_d = grant1;
          if (ALIGN_VSYNC) begin
            state_d = HOLD;
          end else begin
            state_d   = SEND;
            c_valid_d = 1'b1;
            c_addr_d  = sel_addr;
            c_data_d  = sel_data;
          end
        end
      end
      HOLD: begin
        if (vsync_fall) begin
          state_d   = SEND;
          c_valid_d = 1'b1;
          c_addr_d  = hold_addr;
          c_data_d  = hold_data;
        end
      end
      SEND: begin
        if (xfer) begin
          c_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State and registered outputs; vsync_q tracks vsync_in every cycle so an
  // edge arriving on the very cycle HOLD is entered is still seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      idx          <= '0;
      c_valid_r    <= 1'b0;
      c_addr_r     <= '0;
      c_data_r     <= '0;
      hold_addr    <= '0;
      hold_data    <= '0;
      req0_ready_r <= 1'b0;
      req1_ready_r <= 1'b0;
      boot_done_r  <= 1'b0;
      vsync_q      <= 1'b1;
    end else begin
      state        <= state_d;
      idx          <= idx_d;
      c_valid_r    <= c_valid_d;
      c_addr_r     <= c_addr_d;
      c_data_r     <= c_data_d;
      hold_addr    <= hold_addr_d;
      hold_data    <= hold_data_d;
      req0_ready_r <= req0_ready_d;
      req1_ready_r <= req1_ready_d;
      boot_done_r  <= boot_done_d;
      vsync_q      <= vsync_in;
    end
  end

  assign cfg.c_valid = c_valid_r;
  assign cfg.c_addr  = c_addr_r;
  assign cfg.c_data  = c_data_r;
  assign req0_ready  = req0_ready_r;
  assign req1_ready  = req1_ready_r;
  assign boot_done   = boot_done_r;
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

endmodule

// File: tb/tb_vga_config_sequencer.sv
// Randomized self-checking bench for vga_config_sequencer (ALIGN_VSYNC = 1).
module tb_vga_config_sequencer;
  import vga_config_sequencer_pkg::*;

  localparam int W  = 12;
  localparam int NR = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_addr, req0_data, req1_addr, req1_data;
  logic         req0_ready, req1_ready;
  logic         vsync_in;
  logic         boot_done, busy;
  seq_state_t   state_dbg;

  vga_config_sequencer_if #(.CONFIG_WIDTH(W)) cfg_bus ();

  vga_config_sequencer #(.CONFIG_WIDTH(W), .NUM_REGS(NR), .ALIGN_VSYNC(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .vsync_in   (vsync_in),
    .cfg        (cfg_bus),
    .boot_done  (boot_done),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- reference model state ----------------
  int unsigned      boot_tbl [NR] = '{48, 33, 16, 10, 96, 2, 800, 525};
  logic [2*W-1:0]   exp_q [$];
  int               grant_log [$];
  int               checks = 0;
  int               errors = 0;
  int               boot_cnt = 0;
  int               rr_model = 1;
  bit               pending = 0;
  bit               edge_ok = 0;
  int               ready_mode = 0;   // 0: always, 1: one cycle in three, 2: random
  bit               vs_auto = 0;

  // previous-negedge samples
  bit               p_seen = 0;
  logic             p_cv, p_cr, p_vs, p_r0, p_r1, p_v0, p_v1;
  logic [W-1:0]     p_ca, p_cd, p_a0, p_d0, p_a1, p_d1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Round-robin rule: tie goes opposite to last winner, else the lone requester.
  function automatic int rr_pick(input logic v0, input logic v1, input int last);
    if (v0 && v1) return (last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      p_seen = 0;
    end else begin
      logic [2*W-1:0] e;
      int g, eg;
      check_val("boot_done", boot_done, (boot_cnt >= NR) ? 1 : 0);
      if (boot_cnt < NR) check_val("ready_in_boot", {req0_ready, req1_ready}, 0);
      if (p_seen && p_cv && !p_cr) begin
        check_val("stall_valid", cfg_bus.c_valid, 1);
        check_val("stall_addr", cfg_bus.c_addr, p_ca);
        check_val("stall_data", cfg_bus.c_data, p_cd);
      end
      if (pending && !edge_ok) check_val("cvalid_before_vsync", cfg_bus.c_valid, 0);
      if (req0_ready || req1_ready) begin
        check_val("ready_onehot", req0_ready && req1_ready, 0);
        if (req0_ready && p_seen) check_val("ready0_pulse", p_r0, 0);
        if (req1_ready && p_seen) check_val("ready1_pulse", p_r1, 0);
        g  = req1_ready ? 1 : 0;
        eg = p_seen ? rr_pick(p_v0, p_v1, rr_model) : -1;
        check_val("grant_id", g, eg);
        if (eg >= 0) rr_model = eg;
        grant_log.push_back(g);
        exp_q.push_back((eg == 1) ? {p_a1, p_d1} : {p_a0, p_d0});
        pending = 1;
        edge_ok = 0;
      end
      if (pending && p_seen && p_vs && !vsync_in) edge_ok = 1;
      if (cfg_bus.c_valid && cfg_bus.c_ready) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_xfer", cfg_bus.c_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("xfer_addr", cfg_bus.c_addr, e[2*W-1:W]);
          check_val("xfer_data", cfg_bus.c_data, e[W-1:0]);
        end
        if (boot_cnt < NR) boot_cnt++;
        else pending = 0;
      end
      p_seen = 1;
      p_cv = cfg_bus.c_valid;  p_cr = cfg_bus.c_ready;
      p_ca = cfg_bus.c_addr;   p_cd = cfg_bus.c_data;
      p_vs = vsync_in;         p_r0 = req0_ready;  p_r1 = req1_ready;
      p_v0 = req0_valid;       p_a0 = req0_addr;   p_d0 = req0_data;
      p_v1 = req1_valid;       p_a1 = req1_addr;   p_d1 = req1_data;
    end
  end

  // ---------------- background drivers ----------------
  initial begin
    int cyc;
    cyc = 0;
    cfg_bus.c_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (ready_mode)
        0:       cfg_bus.c_ready = 1'b1;
        1:       cfg_bus.c_ready = (cyc % 3 == 0);
        default: cfg_bus.c_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  initial begin
    int k;
    vsync_in = 1'b1;
    forever begin
      k = $urandom_range(3, 10);
      repeat (k) @(posedge clk);
      #1;
      if (vs_auto) begin
        vsync_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vsync_in = 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_model();
    exp_q.delete();
    for (int i = 0; i < NR; i++) exp_q.push_back({W'(i), W'(boot_tbl[i])});
    boot_cnt = 0;
    rr_model = 1;
    pending  = 0;
    edge_ok  = 0;
  endtask

  task automatic check_reset_values();
    check_val("rst_c_valid", cfg_bus.c_valid, 0);
    check_val("rst_c_addr", cfg_bus.c_addr, 0);
    check_val("rst_c_data", cfg_bus.c_data, 0);
    check_val("rst_req0_ready", req0_ready, 0);
    check_val("rst_req1_ready", req1_ready, 0);
    check_val("rst_boot_done", boot_done, 0);
    check_val("rst_busy", busy, 1);
    check_val("rst_state", state_dbg, BOOT);
  endtask

  // Assert reset mid-cycle (no clock edge) and check outputs react at once.
  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    load_model();
    tick(2);
    @(posedge clk); #4;
    rst_n = 1'b1;
  endtask

  task automatic do_req(input int id, input logic [W-1:0] a, input logic [W-1:0] d);
    bit ok;
    ok = 0;
    if (id == 0) begin req0_valid = 1'b1; req0_addr = a; req0_data = d; end
    else         begin req1_valid = 1'b1; req1_addr = a; req1_data = d; end
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
        ok = 1;
        break;
      end
    end
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
    check_val((id == 0) ? "req0_accept" : "req1_accept", ok, 1);
  endtask

  task automatic wait_boot();
    for (int i = 0; i < 1000 && boot_cnt < NR; i++) @(negedge clk);
    check_val("boot_count", boot_cnt, NR);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !pending) break;
    end
    check_val("drain_left", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int exp_order [4] = '{0, 1, 0, 1};
    int r;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    #2;
    check_reset_values();
    load_model();
    tick(2);
    @(posedge clk); #4;
    rst_n = 1'b1;

    // Boot with c_ready tied high, then a tie between both requesters.
    ready_mode = 0;
    wait_boot();
    wait_drain();
    tick(2);
    check_val("idle_busy", busy, 0);
    check_val("idle_state", state_dbg, IDLE);

    vs_auto = 1;
    grant_log.delete();
    fork
      begin
        do_req(0, 12'h011, 12'h101);
        do_req(0, 12'h012, 12'h102);
      end
      begin
        do_req(1, 12'h0f1, 12'h201);
        do_req(1, 12'h0f2, 12'h202);
      end
    join
    wait_drain();
    check_val("order_len", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) check_val("order", grant_log[i], exp_order[i]);

    // Single write held until a manually driven VSync falling edge.
    vs_auto = 0;
    tick(4);
    vsync_in = 1'b1;
    tick(2);
    do_req(0, 12'd6, 12'd1000);
    tick(6);
    check_val("hold_c_valid", cfg_bus.c_valid, 0);
    check_val("hold_busy", busy, 1);
    vsync_in = 1'b0;
    tick(2);
    vsync_in = 1'b1;
    wait_drain();

    // Reset after the 4th boot transfer; table must restart at address 0.
    do_reset();
    for (int i = 0; i < 100 && boot_cnt < 4; i++) @(negedge clk);
    check_val("pre_abort_count", boot_cnt, 4);
    do_reset();

    // Slow c_ready during boot with req1 waiting; req1 must win first.
    ready_mode = 1;
    vs_auto = 1;
    grant_log.delete();
    do_req(1, 12'h0a5, 12'h5a5);
    wait_drain();
    check_val("first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 1);

    // Random traffic, including addresses beyond the table.
    ready_mode = 2;
    for (int n = 0; n < 12; n++) begin
      r = $urandom_range(0, 2);
      if (r == 2) begin
        fork
          do_req(0, W'($urandom_range(0, 15)), W'($urandom));
          do_req(1, W'($urandom_range(0, 15)), W'($urandom));
        join
      end else begin
        do_req(r, W'($urandom_range(0, 15)), W'($urandom));
      end
      wait_drain();
    end

    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_config_sequencer.md
Name: vga_config_sequencer

Overview:
- Owns the VGA config port (c_valid/c_addr/c_data/c_ready).
- After reset, replays a fixed table of 8 timing-register writes: H/V left margin, H/V right margin, H/V sync pulse, H/V count max.
- After the table, arbitrates runtime writes from two requesters (0 = host, 1 = mode-switch) round-robin.
- Optionally holds each runtime write until the start of a VSync pulse, so timing never changes mid-frame.

Parameters:
- CONFIG_WIDTH, 12, width of config address and config data buses
- NUM_REGS, 8, boot table length; register addresses 0..NUM_REGS-1
- ALIGN_VSYNC, 1, 1 = runtime writes wait for VSync falling edge; 0 = issue immediately
- H_LEFT_INIT, 48, boot value for address 0
- V_LEFT_INIT, 33, boot value for address 1
- H_RIGHT_INIT, 16, boot value for address 2
- V_RIGHT_INIT, 10, boot value for address 3
- H_SYNC_INIT, 96, boot value for address 4
- V_SYNC_INIT, 2, boot value for address 5
- H_MAX_INIT, 800, boot value for address 6
- V_MAX_INIT, 525, boot value for address 7

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  host write request
- req0_addr  in  CONFIG_WIDTH  host register address
- req0_data  in  CONFIG_WIDTH  host register data
- req0_ready  out  1  one-cycle accept pulse to host
- req1_valid, req1_addr, req1_data, req1_ready  same as req0, for the mode-switch requester
- vsync_in  in  1  VGA VSync (active-low pulse)
- c_valid  out  1  config write valid to VGA
- c_addr  out  CONFIG_WIDTH  config address to VGA
- c_data  out  CONFIG_WIDTH  config data to VGA
- c_ready  in  1  VGA config accept
- boot_done  out  1  high once all table writes are complete
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state = BOOT, idx = 0, c_valid = 0, c_addr = 0, c_data = 0, req0_ready = 0, req1_ready = 0, boot_done = 0, busy = 1, rr_last = 1 (so req0 wins the first tie), vsync_q = 1.
- Config handshake:
  - A transfer occurs in a cycle where c_valid && c_ready.
  - c_addr/c_data are registered and stay stable while c_valid = 1.
  - c_valid deasserts the cycle after the transfer.
  - c_ready high in the same cycle c_valid rises completes the transfer in that cycle.
- BOOT:
  - Drives c_valid = 1, c_addr = idx, c_data = table[idx].
  - On transfer: idx + 1. Back-to-back is allowed, so the next entry is presented in the cycle after the transfer, with c_valid kept high.
  - Transfer of idx = NUM_REGS-1 -> IDLE, boot_done = 1 (sticky until reset).
  - req*_ready stay 0 throughout BOOT.
- IDLE:
  - If any req*_valid: grant one requester, latching addr and data into hold registers, and pulse its reqN_ready for exactly 1 cycle.
  - Next state: HOLD if ALIGN_VSYNC = 1, else SEND.
  - Grant rule: both valid -> grant the requester opposite to rr_last. Only one valid -> grant it. Update rr_last to the granted requester.
- HOLD:
  - vsync_q <= vsync_in every cycle.
  - vsync_q = 1 && vsync_in = 0 (falling edge) -> SEND.
  - An edge present in the same cycle HOLD is entered counts.
- SEND:
  - c_valid = 1 with the held addr and data.
  - On transfer -> IDLE. Earliest new grant is the cycle after returning to IDLE, giving at most 1 grant per 2 cycles.
- No requests are queued beyond the single hold register. Requesters keep valid asserted until they see ready.
- Addresses >= NUM_REGS are forwarded unchanged.
- Reset mid-BOOT or mid-SEND aborts: c_valid drops immediately and the table replays from idx 0.
- busy = (state != IDLE).
- Single clock domain; vsync_in is same-clock, so no synchronizer.

Decomposition:
- Shared width-parameter include carries CONFIG_WIDTH, NUM_REGS, register address constants (ADDR_H_LEFT = 0 … ADDR_V_MAX = 7) and state encodings (BOOT, IDLE, HOLD, SEND).
- One natural sub-module, vga_cfg_rr_arbiter: 2-way round-robin grant with an rr_last register.

Test Plan:
- Reset, c_ready tied 1 -> 8 consecutive transfers, addr 0..7, data 48,33,16,10,96,2,800,525; boot_done rises the cycle after the addr 7 transfer.
- c_ready toggling 1-of-3 cycles during boot -> c_addr/c_data never change while c_valid = 1 and c_ready = 0; still exactly 8 transfers.
- ALIGN_VSYNC = 1, req0 writes addr 6 data 1000 -> req0_ready pulses 1 cycle; c_valid stays low until vsync_in falls; then one transfer with addr 6, data 1000.
- req0 and req1 both held valid for 4 grants -> grant order 0,1,0,1.
- req1_valid asserted during BOOT -> req1_ready stays 0 until boot_done; first grant goes to req1.
- rst_n pulsed low after the 4th boot transfer -> all outputs return to reset values asynchronously; table restarts at addr 0.
